// File: rtl/pipeline_pkg.sv
// Shared types and constants for the fetch/decode pipeline boundary.
package pipeline_pkg;

  localparam logic [15:0] NOP_WORD             = 16'h0000;
  localparam int unsigned IMM_FLAG_BIT_DEFAULT = 15;

  typedef enum logic {
    S_FIRST = 1'b0,
    S_IMM   = 1'b1
  } fd_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fd_pipeline_register.sv
// Fetch/decode stage register: assembles opcode+immediate pairs and presents one
// instruction per valid cycle, honouring stall (hold) and flush (bubble).
module fd_pipeline_register
  import pipeline_pkg::*;
#(
  parameter int unsigned WORD_W       = 16,
  parameter int unsigned IMM_FLAG_BIT = IMM_FLAG_BIT_DEFAULT,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] fetch_word_IN,
  input  logic [WORD_W-1:0] fetch_pc_IN,
  input  logic              fetch_valid_IN,
  input  logic              stall,
  input  logic              flush,
  output logic [WORD_W-1:0] instruction_OUT,
  output logic [WORD_W-1:0] immediate_OUT,
  output logic [WORD_W-1:0] pc_OUT,
  output logic              valid_OUT,
  output logic              two_word_OUT,
  output logic              waiting_imm_OUT,
  output logic [CNT_W-1:0]  bubble_count_OUT
);

  localparam logic [WORD_W-1:0] Nop = WORD_W'(NOP_WORD);

  fd_state_t         state_q, state_d;
  logic [WORD_W-1:0] op_buf_q, op_buf_d;
  logic [WORD_W-1:0] pc_buf_q, pc_buf_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] imm_q, imm_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              two_q, two_d;
  logic              bubble_inc;

  always_comb begin
    state_d    = state_q;
    op_buf_d   = op_buf_q;
    pc_buf_d   = pc_buf_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    two_d      = two_q;
    bubble_inc = 1'b0;

    if (flush) begin
      state_d    = S_FIRST;
      op_buf_d   = '0;
      pc_buf_d   = '0;
      instr_d    = Nop;
      imm_d      = '0;
      pc_d       = '0;
      valid_d    = 1'b0;
      two_d      = 1'b0;
      bubble_inc = 1'b1;
    end else if (!stall) begin
      if (!fetch_valid_IN) begin
        // Pending S_IMM keeps its buffered opcode; pc_OUT is left as-is.
        instr_d    = Nop;
        imm_d      = '0;
        valid_d    = 1'b0;
        two_d      = 1'b0;
        bubble_inc = 1'b1;
      end else if (state_q == S_IMM) begin
        instr_d = op_buf_q;
        pc_d    = pc_buf_q;
        imm_d   = fetch_word_IN;
        valid_d = 1'b1;
        two_d   = 1'b1;
        state_d = S_FIRST;
      end else if (fetch_word_IN[IMM_FLAG_BIT]) begin
        op_buf_d   = fetch_word_IN;
        pc_buf_d   = fetch_pc_IN;
        instr_d    = Nop;
        imm_d      = '0;
        pc_d       = '0;
        valid_d    = 1'b0;
        two_d      = 1'b0;
        state_d    = S_IMM;
        bubble_inc = 1'b1;
      end else begin
        instr_d = fetch_word_IN;
        pc_d    = fetch_pc_IN;
        imm_d   = '0;
        valid_d = 1'b1;
        two_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FIRST;
      op_buf_q <= '0;
      pc_buf_q <= '0;
      instr_q  <= Nop;
      imm_q    <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      two_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_buf_q <= op_buf_d;
      pc_buf_q <= pc_buf_d;
      instr_q  <= instr_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      two_q    <= two_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk_i  (clk),
    .clear_i(reset),
    .inc_i  (bubble_inc),
    .count_o(bubble_count_OUT)
  );

  assign instruction_OUT = instr_q;
  assign immediate_OUT   = imm_q;
  assign pc_OUT          = pc_q;
  assign valid_OUT       = valid_q;
  assign two_word_OUT    = two_q;
  assign waiting_imm_OUT = (state_q == S_IMM);

endmodule

// File: tb/tb_fd_pipeline_register.sv
// Directed vector bench for fd_pipeline_register, with a narrow-counter instance for saturation.
module tb_fd_pipeline_register;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] fetch_word_IN = '0;
  logic [15:0] fetch_pc_IN = '0;
  logic        fetch_valid_IN = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic [15:0] instr, imm, pc;
  logic        valid, two, waiting;
  logic [15:0] cnt;

  logic [15:0] s_instr, s_imm, s_pc;
  logic        s_valid, s_two, s_waiting;
  logic [1:0]  s_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fd_pipeline_register dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_word_IN   (fetch_word_IN),
    .fetch_pc_IN     (fetch_pc_IN),
    .fetch_valid_IN  (fetch_valid_IN),
    .stall           (stall),
    .flush           (flush),
    .instruction_OUT (instr),
    .immediate_OUT   (imm),
    .pc_OUT          (pc),
    .valid_OUT       (valid),
    .two_word_OUT    (two),
    .waiting_imm_OUT (waiting),
    .bubble_count_OUT(cnt)
  );

  fd_pipeline_register #(
    .CNT_W(2)
  ) dut_small (
    .clk             (clk),
    .reset           (reset),
    .fetch_word_IN   (fetch_word_IN),
    .fetch_pc_IN     (fetch_pc_IN),
    .fetch_valid_IN  (fetch_valid_IN),
    .stall           (stall),
    .flush           (flush),
    .instruction_OUT (s_instr),
    .immediate_OUT   (s_imm),
    .pc_OUT          (s_pc),
    .valid_OUT       (s_valid),
    .two_word_OUT    (s_two),
    .waiting_imm_OUT (s_waiting),
    .bubble_count_OUT(s_cnt)
  );

  typedef struct {
    logic        rst;
    logic        fv;
    logic        st;
    logic        fl;
    logic [15:0] word;
    logic [15:0] wpc;
    logic [15:0] e_instr;
    logic [15:0] e_imm;
    logic [15:0] e_pc;
    logic        e_valid;
    logic        e_two;
    logic        e_wait;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic drive(input logic rst, input logic fv, input logic st, input logic fl,
                       input logic [15:0] word, input logic [15:0] wpc);
    @(negedge clk);
    reset          = rst;
    fetch_valid_IN = fv;
    stall          = st;
    flush          = fl;
    fetch_word_IN  = word;
    fetch_pc_IN    = wpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rst  fv   st   fl   word     pc       instr    imm      pc       v    two  wait cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0123, 16'h0010, 16'h0123, 16'h0000, 16'h0010, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h5555, 16'h0030, 16'h0123, 16'h0000, 16'h0010, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h8A01, 16'h0032, 16'h0123, 16'h0000, 16'h0010, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h7777, 16'h0034, 16'h0123, 16'h0000, 16'h0010, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h8A01, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0022, 16'h8A01, 16'hBEEF, 16'h0020, 1'b1, 1'b1, 1'b0, 16'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0024, 16'h0000, 16'h0000, 16'h0020, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h8A01, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd3};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h2222, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd4};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0777, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd5};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0042, 16'h0044, 16'h0042, 16'h0000, 16'h0044, 1'b1, 1'b0, 1'b0, 16'd5};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h8001, 16'h0050, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd6};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h0052, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h9999, 16'h0060, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hC0DE, 16'h0062, 16'h9999, 16'hC0DE, 16'h0060, 1'b1, 1'b1, 1'b0, 16'd1};

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].fv, vecs[i].st, vecs[i].fl, vecs[i].word, vecs[i].wpc);
      n_vec++;
      if ({instr, imm, pc, valid, two, waiting, cnt} !==
          {vecs[i].e_instr, vecs[i].e_imm, vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_two,
           vecs[i].e_wait, vecs[i].e_cnt}) begin
        n_bad++;
        $display("FAIL vec%0d: got instr=%h imm=%h pc=%h v=%b two=%b wait=%b cnt=%0d, want instr=%h imm=%h pc=%h v=%b two=%b wait=%b cnt=%0d",
                 i, instr, imm, pc, valid, two, waiting, cnt,
                 vecs[i].e_instr, vecs[i].e_imm, vecs[i].e_pc, vecs[i].e_valid,
                 vecs[i].e_two, vecs[i].e_wait, vecs[i].e_cnt);
      end
    end

    // Narrow counter: five idle cycles after reset must saturate at 3.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n_vec++;
    if (s_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL sat_reset: got cnt=%0d, want 0", s_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      logic [1:0] e;
      e = (k < 3) ? 2'(k + 1) : 2'd3;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      n_vec++;
      if (s_cnt !== e || s_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL sat_idle%0d: got cnt=%0d v=%b, want cnt=%0d v=0", k, s_cnt, s_valid, e);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
